// File: rtl/rob_commit_pkg.sv
// Shared types and sizes for the in-order retirement buffer feeding the 8x16 register file.
package rob_commit_pkg;

  localparam int REG_W      = 16;
  localparam int REG_ADDR_W = 3;
  localparam int ROB_DEPTH  = 16;

  typedef struct packed {
    logic                  done;
    logic                  wen;
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_W-1:0]      data;
  } rob_entry_t;

endpackage

// File: rtl/rob_entry_array.sv
// Entry storage: one allocate port, two completion write ports and two combinational
// read ports (head and head+1).
module rob_entry_array
  import rob_commit_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  alloc_en_i,
  input  logic [TAG_W-1:0]      alloc_idx_i,
  input  logic                  alloc_wen_i,
  input  logic [REG_ADDR_W-1:0] alloc_dest_i,
  input  logic                  cmp0_en_i,
  input  logic [TAG_W-1:0]      cmp0_idx_i,
  input  logic [REG_W-1:0]      cmp0_data_i,
  input  logic                  cmp1_en_i,
  input  logic [TAG_W-1:0]      cmp1_idx_i,
  input  logic [REG_W-1:0]      cmp1_data_i,
  input  logic [TAG_W-1:0]      rd0_idx_i,
  input  logic [TAG_W-1:0]      rd1_idx_i,
  output rob_entry_t            rd0_o,
  output rob_entry_t            rd1_o
);

  logic [DEPTH-1:0]      done_q;
  logic [DEPTH-1:0]      wen_q;
  logic [REG_ADDR_W-1:0] dest_q [DEPTH];
  logic [REG_W-1:0]      data_q [DEPTH];

  // NOTE: only the done bits are reset; wen/dest/data are never observed unless done is
  // set, so they stay a plain RAM without reset or clear logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= '0;
    end else if (clear_i) begin
      done_q <= '0;
    end else begin
      if (alloc_en_i) done_q[alloc_idx_i] <= 1'b0;
      if (cmp0_en_i)  done_q[cmp0_idx_i]  <= 1'b1;
      if (cmp1_en_i)  done_q[cmp1_idx_i]  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_en_i) begin
      wen_q[alloc_idx_i]  <= alloc_wen_i;
      dest_q[alloc_idx_i] <= alloc_dest_i;
    end
    if (cmp0_en_i) data_q[cmp0_idx_i] <= cmp0_data_i;
    if (cmp1_en_i) data_q[cmp1_idx_i] <= cmp1_data_i;
  end

  always_comb begin
    rd0_o.done = done_q[rd0_idx_i];
    rd0_o.wen  = wen_q[rd0_idx_i];
    rd0_o.dest = dest_q[rd0_idx_i];
    rd0_o.data = data_q[rd0_idx_i];
    rd1_o.done = done_q[rd1_idx_i];
    rd1_o.wen  = wen_q[rd1_idx_i];
    rd1_o.dest = dest_q[rd1_idx_i];
    rd1_o.data = data_q[rd1_idx_i];
  end

endmodule

// File: rtl/rob_commit.sv
// In-order retirement buffer: program-order allocate, out-of-order completion,
// up to two oldest completed entries retire per cycle onto the register file write ports.
module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  disp_valid,
  input  logic                  disp_wen,
  input  logic [REG_ADDR_W-1:0] disp_dest,
  output logic                  disp_ready,
  output logic [TAG_W-1:0]      disp_tag,
  input  logic                  cmp0_valid,
  input  logic [TAG_W-1:0]      cmp0_tag,
  input  logic [REG_W-1:0]      cmp0_data,
  input  logic                  cmp1_valid,
  input  logic [TAG_W-1:0]      cmp1_tag,
  input  logic [REG_W-1:0]      cmp1_data,
  output logic                  wen0,
  output logic [REG_ADDR_W-1:0] waddr0,
  output logic [REG_W-1:0]      wdata0,
  output logic                  wen1,
  output logic [REG_ADDR_W-1:0] waddr1,
  output logic [REG_W-1:0]      wdata1,
  output logic [1:0]            retire_cnt,
  output logic                  empty
);

  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d, head_nxt;
  logic [TAG_W:0]   count_q, count_d;
  logic             accept, slot0, slot1;
  rob_entry_t       ent0, ent1;

  // Full/empty come from the registered count only: no same-cycle retire bypass.
  assign disp_ready = (count_q != (TAG_W+1)'(DEPTH));
  assign disp_tag   = tail_q;
  assign empty      = (count_q == '0);
  assign accept     = disp_valid && disp_ready && !flush;
  assign head_nxt   = head_q + TAG_W'(1);

  rob_entry_array #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_entries (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (flush),
    .alloc_en_i   (accept),
    .alloc_idx_i  (tail_q),
    .alloc_wen_i  (disp_wen),
    .alloc_dest_i (disp_dest),
    .cmp0_en_i    (cmp0_valid && !flush),
    .cmp0_idx_i   (cmp0_tag),
    .cmp0_data_i  (cmp0_data),
    .cmp1_en_i    (cmp1_valid && !flush),
    .cmp1_idx_i   (cmp1_tag),
    .cmp1_data_i  (cmp1_data),
    .rd0_idx_i    (head_q),
    .rd1_idx_i    (head_nxt),
    .rd0_o        (ent0),
    .rd1_o        (ent1)
  );

  // NOTE: every output gets a default first, so no branch can leave one unassigned
  // and infer a latch.
  always_comb begin
    wen0   = 1'b0;
    waddr0 = '0;
    wdata0 = '0;
    wen1   = 1'b0;
    waddr1 = '0;
    wdata1 = '0;
    slot0  = !flush && (count_q != '0) && ent0.done;
    slot1  = slot0 && (count_q >= (TAG_W+1)'(2)) && ent1.done;
    if (slot0) begin
      wen0   = ent0.wen;
      waddr0 = ent0.dest;
      wdata0 = ent0.data;
    end
    if (slot1) begin
      wen1   = ent1.wen;
      waddr1 = ent1.dest;
      wdata1 = ent1.data;
    end
    retire_cnt = {1'b0, slot0} + {1'b0, slot1};
  end

  always_comb begin
    head_d  = head_q + TAG_W'(retire_cnt);
    tail_d  = tail_q + TAG_W'(accept);
    count_d = count_q + (TAG_W+1)'(accept) - (TAG_W+1)'(retire_cnt);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments only; the _d values above are
  // computed with blocking assignments in combinational blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: directed scenarios plus a randomized run
// against a queue-based model of the retirement buffer.
module tb_rob_commit;

  localparam int DEPTH = 16;
  localparam int TAG_W = 4;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        disp_valid, disp_wen;
  logic [2:0]  disp_dest;
  logic        disp_ready;
  logic [3:0]  disp_tag;
  logic        cmp0_valid, cmp1_valid;
  logic [3:0]  cmp0_tag, cmp1_tag;
  logic [15:0] cmp0_data, cmp1_data;
  logic        wen0, wen1;
  logic [2:0]  waddr0, waddr1;
  logic [15:0] wdata0, wdata1;
  logic [1:0]  retire_cnt;
  logic        empty;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rob_commit #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .disp_valid (disp_valid),
    .disp_wen   (disp_wen),
    .disp_dest  (disp_dest),
    .disp_ready (disp_ready),
    .disp_tag   (disp_tag),
    .cmp0_valid (cmp0_valid),
    .cmp0_tag   (cmp0_tag),
    .cmp0_data  (cmp0_data),
    .cmp1_valid (cmp1_valid),
    .cmp1_tag   (cmp1_tag),
    .cmp1_data  (cmp1_data),
    .wen0       (wen0),
    .waddr0     (waddr0),
    .wdata0     (wdata0),
    .wen1       (wen1),
    .waddr1     (waddr1),
    .wdata1     (wdata1),
    .retire_cnt (retire_cnt),
    .empty      (empty)
  );

  // Register file fed by the write ports; port 1 is applied last.
  logic [15:0] rf [8];
  always @(posedge clk) begin
    if (wen0) rf[waddr0] <= wdata0;
    if (wen1) rf[waddr1] <= wdata1;
  end

  // Illegal completion detection: same tag on both ports, or a tag not in flight.
  logic [3:0] a_head, off0, off1;
  logic [4:0] a_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_head <= '0;
      a_cnt  <= '0;
    end else if (flush) begin
      a_head <= '0;
      a_cnt  <= '0;
    end else begin
      off0 = cmp0_tag - a_head;
      off1 = cmp1_tag - a_head;
      if (cmp0_valid && cmp1_valid)
        assert (cmp0_tag != cmp1_tag) else $error("illegal completion: same tag %0d on both ports", cmp0_tag);
      if (cmp0_valid)
        assert ({1'b0, off0} < a_cnt) else $error("illegal completion: port0 tag %0d not in flight", cmp0_tag);
      if (cmp1_valid)
        assert ({1'b0, off1} < a_cnt) else $error("illegal completion: port1 tag %0d not in flight", cmp1_tag);
      a_head <= a_head + 4'(retire_cnt);
      a_cnt  <= a_cnt + 5'(disp_valid && disp_ready) - 5'(retire_cnt);
    end
  end

  // Behavioural model: program-order queue of in-flight instructions.
  typedef struct {
    logic [3:0]  tag;
    logic        wen;
    logic [2:0]  dest;
    logic        done;
    logic [15:0] data;
  } m_entry_t;

  m_entry_t   mq[$];
  logic [3:0] m_tail;

  task automatic idle();
    flush = 0; disp_valid = 0; disp_wen = 0; disp_dest = 0;
    cmp0_valid = 0; cmp0_tag = 0; cmp0_data = 0;
    cmp1_valid = 0; cmp1_tag = 0; cmp1_data = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    idle();
    flush = 1;
    next_cycle();
    flush = 0;
  endtask

  task automatic dispatch(input logic w, input logic [2:0] d);
    idle();
    disp_valid = 1; disp_wen = w; disp_dest = d;
    next_cycle();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (empty !== 1 || disp_ready !== 1 || wen0 !== 0 || wen1 !== 0 || retire_cnt !== 0 ||
          disp_tag !== 0 || waddr0 !== 0 || wdata0 !== 0 || waddr1 !== 0 || wdata1 !== 0) begin
        n_err++;
        $display("FAIL reset_idle cyc %0d: empty=%b ready=%b wen0=%b wen1=%b rc=%0d tag=%0d wa0=%0d wd0=%h wa1=%0d wd1=%h, want 1 1 0 0 0 0 0 0 0 0",
                 i, empty, disp_ready, wen0, wen1, retire_cnt, disp_tag, waddr0, wdata0, waddr1, wdata1);
      end
    end
    next_cycle();
  endtask

  task automatic test_out_of_order();
    idle();
    disp_valid = 1; disp_wen = 1; disp_dest = 3;
    @(negedge clk);
    n_cmp++;
    if (disp_tag !== 0 || disp_ready !== 1) begin
      n_err++; $display("FAIL ooo_tag0: tag=%0d ready=%b, want 0 1", disp_tag, disp_ready);
    end
    next_cycle();
    disp_dest = 5;
    @(negedge clk);
    n_cmp++;
    if (disp_tag !== 1) begin
      n_err++; $display("FAIL ooo_tag1: tag=%0d, want 1", disp_tag);
    end
    next_cycle();
    idle();
    cmp0_valid = 1; cmp0_tag = 1; cmp0_data = 16'h00AA;
    @(negedge clk);
    n_cmp++;
    if (retire_cnt !== 0 || wen0 !== 0 || wen1 !== 0) begin
      n_err++; $display("FAIL ooo_wait1: rc=%0d wen0=%b wen1=%b, want 0 0 0", retire_cnt, wen0, wen1);
    end
    next_cycle();
    cmp0_tag = 0; cmp0_data = 16'h0055;
    @(negedge clk);
    n_cmp++;
    if (retire_cnt !== 0 || wen0 !== 0 || wen1 !== 0) begin
      n_err++; $display("FAIL ooo_wait2: rc=%0d wen0=%b wen1=%b, want 0 0 0", retire_cnt, wen0, wen1);
    end
    next_cycle();
    idle();
    @(negedge clk);
    n_cmp++;
    if (wen0 !== 1 || waddr0 !== 3 || wdata0 !== 16'h0055 || wen1 !== 1 || waddr1 !== 5 ||
        wdata1 !== 16'h00AA || retire_cnt !== 2) begin
      n_err++;
      $display("FAIL ooo_retire: wen0=%b wa0=%0d wd0=%h wen1=%b wa1=%0d wd1=%h rc=%0d, want 1 3 0055 1 5 00aa 2",
               wen0, waddr0, wdata0, wen1, waddr1, wdata1, retire_cnt);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (empty !== 1 || retire_cnt !== 0 || rf[3] !== 16'h0055 || rf[5] !== 16'h00AA) begin
      n_err++;
      $display("FAIL ooo_after: empty=%b rc=%0d rf3=%h rf5=%h, want 1 0 0055 00aa", empty, retire_cnt, rf[3], rf[5]);
    end
    next_cycle();
  endtask

  task automatic test_same_dest();
    dispatch(1, 2);
    dispatch(1, 2);
    cmp0_valid = 1; cmp0_tag = 2; cmp0_data = 16'h1111;
    cmp1_valid = 1; cmp1_tag = 3; cmp1_data = 16'h2222;
    next_cycle();
    idle();
    @(negedge clk);
    n_cmp++;
    if (wen0 !== 1 || waddr0 !== 2 || wdata0 !== 16'h1111 || wen1 !== 1 || waddr1 !== 2 ||
        wdata1 !== 16'h2222 || retire_cnt !== 2) begin
      n_err++;
      $display("FAIL same_dest_ports: wen0=%b wa0=%0d wd0=%h wen1=%b wa1=%0d wd1=%h rc=%0d, want 1 2 1111 1 2 2222 2",
               wen0, waddr0, wdata0, wen1, waddr1, wdata1, retire_cnt);
    end
    next_cycle();
    n_cmp++;
    if (rf[2] !== 16'h2222) begin
      n_err++; $display("FAIL same_dest_rf: rf2=%h, want 2222", rf[2]);
    end
  endtask

  task automatic test_full();
    do_flush();
    for (int i = 0; i < DEPTH; i++) begin
      disp_valid = 1; disp_wen = 1; disp_dest = 3'(i);
      @(negedge clk);
      n_cmp++;
      if (disp_ready !== 1 || disp_tag !== 4'(i)) begin
        n_err++; $display("FAIL full_fill %0d: ready=%b tag=%0d, want 1 %0d", i, disp_ready, disp_tag, i);
      end
      next_cycle();
    end
    @(negedge clk);
    n_cmp++;
    if (disp_ready !== 0 || empty !== 0) begin
      n_err++; $display("FAIL full_17th: ready=%b empty=%b, want 0 0", disp_ready, empty);
    end
    next_cycle();
    idle();
    cmp0_valid = 1; cmp0_tag = 0; cmp0_data = 16'hBEEF;
    @(negedge clk);
    n_cmp++;
    if (retire_cnt !== 0 || disp_ready !== 0) begin
      n_err++; $display("FAIL full_cmp: rc=%0d ready=%b, want 0 0", retire_cnt, disp_ready);
    end
    next_cycle();
    idle();
    disp_valid = 1; disp_wen = 1; disp_dest = 7;
    @(negedge clk);
    n_cmp++;
    if (retire_cnt !== 1 || wen0 !== 1 || waddr0 !== 0 || wdata0 !== 16'hBEEF || wen1 !== 0 || disp_ready !== 0) begin
      n_err++;
      $display("FAIL full_retire: rc=%0d wen0=%b wa0=%0d wd0=%h wen1=%b ready=%b, want 1 1 0 beef 0 0",
               retire_cnt, wen0, waddr0, wdata0, wen1, disp_ready);
    end
    next_cycle();
    idle();
    @(negedge clk);
    n_cmp++;
    if (disp_ready !== 1 || disp_tag !== 0) begin
      n_err++; $display("FAIL full_wrap: ready=%b tag=%0d, want 1 0", disp_ready, disp_tag);
    end
    next_cycle();
  endtask

  task automatic test_no_wen();
    do_flush();
    dispatch(0, 6);
    dispatch(1, 1);
    cmp0_valid = 1; cmp0_tag = 0; cmp0_data = 16'h1234;
    next_cycle();
    idle();
    @(negedge clk);
    n_cmp++;
    if (retire_cnt !== 1 || wen0 !== 0 || wen1 !== 0) begin
      n_err++; $display("FAIL no_wen_retire: rc=%0d wen0=%b wen1=%b, want 1 0 0", retire_cnt, wen0, wen1);
    end
    next_cycle();
    cmp1_valid = 1; cmp1_tag = 1; cmp1_data = 16'h0777;
    next_cycle();
    idle();
    @(negedge clk);
    n_cmp++;
    if (retire_cnt !== 1 || wen0 !== 1 || waddr0 !== 1 || wdata0 !== 16'h0777) begin
      n_err++;
      $display("FAIL no_wen_advance: rc=%0d wen0=%b wa0=%0d wd0=%h, want 1 1 1 0777", retire_cnt, wen0, waddr0, wdata0);
    end
    next_cycle();
  endtask

  task automatic test_flush();
    do_flush();
    for (int i = 0; i < 5; i++) dispatch(1, 3'(i));
    cmp0_valid = 1; cmp0_tag = 0; cmp0_data = 16'hAAAA;
    cmp1_valid = 1; cmp1_tag = 1; cmp1_data = 16'hBBBB;
    next_cycle();
    idle();
    flush = 1; disp_valid = 1; disp_wen = 1; disp_dest = 7;
    cmp0_valid = 1; cmp0_tag = 2; cmp0_data = 16'hCCCC;
    @(negedge clk);
    n_cmp++;
    if (wen0 !== 0 || wen1 !== 0 || retire_cnt !== 0) begin
      n_err++; $display("FAIL flush_cycle: wen0=%b wen1=%b rc=%0d, want 0 0 0", wen0, wen1, retire_cnt);
    end
    next_cycle();
    idle();
    @(negedge clk);
    n_cmp++;
    if (empty !== 1 || disp_tag !== 0 || disp_ready !== 1) begin
      n_err++; $display("FAIL flush_after: empty=%b tag=%0d ready=%b, want 1 0 1", empty, disp_tag, disp_ready);
    end
    next_cycle();
    dispatch(1, 4);
    @(negedge clk);
    n_cmp++;
    if (retire_cnt !== 0 || wen0 !== 0) begin
      n_err++; $display("FAIL flush_done_cleared: rc=%0d wen0=%b, want 0 0", retire_cnt, wen0);
    end
    next_cycle();
  endtask

  task automatic test_random();
    int          pend[$];
    int          k, nret;
    logic        r0, r1, e_wen0, e_wen1, e_ready, acc;
    logic [2:0]  e_wa0, e_wa1;
    logic [15:0] e_wd0, e_wd1;
    m_entry_t    ne;
    do_flush();
    mq.delete();
    m_tail = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      idle();
      flush      = ($urandom_range(0, 63) == 0);
      disp_valid = ($urandom_range(0, 3) != 0);
      disp_wen   = ($urandom_range(0, 3) != 0);
      disp_dest  = 3'($urandom);
      pend.delete();
      foreach (mq[i]) if (!mq[i].done) pend.push_back(i);
      if (pend.size() > 0 && $urandom_range(0, 3) < ((cyc % 200) < 100 ? 1 : 3)) begin
        k = $urandom_range(0, pend.size() - 1);
        cmp0_valid = 1; cmp0_tag = mq[pend[k]].tag; cmp0_data = 16'($urandom);
        pend.delete(k);
      end
      if (pend.size() > 0 && $urandom_range(0, 3) < ((cyc % 200) < 100 ? 1 : 3)) begin
        k = $urandom_range(0, pend.size() - 1);
        cmp1_valid = 1; cmp1_tag = mq[pend[k]].tag; cmp1_data = 16'($urandom);
      end
      e_ready = (mq.size() < DEPTH);
      r0 = !flush && mq.size() >= 1 && mq[0].done;
      r1 = r0 && mq.size() >= 2 && mq[1].done;
      e_wen0 = r0 && mq[0].wen;  e_wa0 = r0 ? mq[0].dest : 3'd0;  e_wd0 = r0 ? mq[0].data : 16'd0;
      e_wen1 = r1 && mq[1].wen;  e_wa1 = r1 ? mq[1].dest : 3'd0;  e_wd1 = r1 ? mq[1].data : 16'd0;
      nret = int'(r0) + int'(r1);
      @(negedge clk);
      n_cmp++;
      if (disp_ready !== e_ready || disp_tag !== m_tail || empty !== (mq.size() == 0)) begin
        n_err++;
        $display("FAIL rand_disp cyc %0d: ready=%b tag=%0d empty=%b, want %b %0d %b",
                 cyc, disp_ready, disp_tag, empty, e_ready, m_tail, mq.size() == 0);
      end
      n_cmp++;
      if (retire_cnt !== 2'(nret)) begin
        n_err++; $display("FAIL rand_rc cyc %0d: rc=%0d, want %0d", cyc, retire_cnt, nret);
      end
      n_cmp++;
      if (wen0 !== e_wen0 || waddr0 !== e_wa0 || wdata0 !== e_wd0) begin
        n_err++;
        $display("FAIL rand_slot0 cyc %0d: wen=%b wa=%0d wd=%h, want %b %0d %h", cyc, wen0, waddr0, wdata0, e_wen0, e_wa0, e_wd0);
      end
      n_cmp++;
      if (wen1 !== e_wen1 || waddr1 !== e_wa1 || wdata1 !== e_wd1) begin
        n_err++;
        $display("FAIL rand_slot1 cyc %0d: wen=%b wa=%0d wd=%h, want %b %0d %h", cyc, wen1, waddr1, wdata1, e_wen1, e_wa1, e_wd1);
      end
      if (flush) begin
        mq.delete();
        m_tail = 0;
      end else begin
        acc = disp_valid && e_ready;
        foreach (mq[i]) begin
          if (cmp0_valid && mq[i].tag == cmp0_tag) begin mq[i].done = 1; mq[i].data = cmp0_data; end
          if (cmp1_valid && mq[i].tag == cmp1_tag) begin mq[i].done = 1; mq[i].data = cmp1_data; end
        end
        repeat (nret) void'(mq.pop_front());
        if (acc) begin
          ne.tag = m_tail; ne.wen = disp_wen; ne.dest = disp_dest; ne.done = 0; ne.data = 0;
          mq.push_back(ne);
          m_tail = m_tail + 4'd1;
        end
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_reset_midstream();
    do_flush();
    dispatch(1, 3);
    dispatch(1, 4);
    cmp0_valid = 1; cmp0_tag = 0; cmp0_data = 16'h5A5A;
    next_cycle();
    idle();
    @(negedge clk);
    n_cmp++;
    if (wen0 !== 1 || wdata0 !== 16'h5A5A) begin
      n_err++; $display("FAIL rst_mid_pre: wen0=%b wd0=%h, want 1 5a5a", wen0, wdata0);
    end
    #2 rst = 1;
    #1;
    n_cmp++;
    if (wen0 !== 0 || wen1 !== 0 || retire_cnt !== 0 || empty !== 1 || disp_ready !== 1 ||
        disp_tag !== 0 || waddr0 !== 0 || wdata0 !== 0) begin
      n_err++;
      $display("FAIL rst_mid_async: wen0=%b wen1=%b rc=%0d empty=%b ready=%b tag=%0d wa0=%0d wd0=%h, want 0 0 0 1 1 0 0 0",
               wen0, wen1, retire_cnt, empty, disp_ready, disp_tag, waddr0, wdata0);
    end
    @(posedge clk);
    #1 rst = 0;
    dispatch(1, 2);
    @(negedge clk);
    n_cmp++;
    if (wen0 !== 0 || retire_cnt !== 0 || empty !== 0 || disp_tag !== 1) begin
      n_err++;
      $display("FAIL rst_mid_after: wen0=%b rc=%0d empty=%b tag=%0d, want 0 0 0 1", wen0, retire_cnt, empty, disp_tag);
    end
    next_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_out_of_order();
    test_same_dest();
    test_full();
    test_no_wen();
    test_flush();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- In-order retirement buffer that drives the architectural register file's two write ports (wen0/waddr0/wdata0, wen1/waddr1/wdata1).
- Dispatch allocates entries in program order. Functional units return results out of order on two completion ports.
- Up to two oldest completed entries retire per cycle as register writes.
- Sits between the out-of-order execution back end and the 8x16 register file.

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 4.
- TAG_W, 4, entry tag width; equals log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  discard all entries (mispredict recovery).
- disp_valid  in  1  dispatch request.
- disp_wen  in  1  instruction writes a register.
- disp_dest  in  3  destination register.
- disp_ready  out  1  entry available, i.e. not full.
- disp_tag  out  TAG_W  tag assigned to an accepted dispatch (tail pointer).
- cmp0_valid  in  1  completion port 0 valid.
- cmp0_tag  in  TAG_W  completing entry for port 0.
- cmp0_data  in  16  result for port 0.
- cmp1_valid, cmp1_tag, cmp1_data  in  1/TAG_W/16  completion port 1, same meaning as port 0.
- wen0, waddr0, wdata0  out  1/3/16  retire slot 0, the older entry.
- wen1, waddr1, wdata1  out  1/3/16  retire slot 1, the younger entry.
- retire_cnt  out  2  entries retired this cycle (0..2).
- empty  out  1  no entries held.

Behaviour:
- State:
  - head and tail pointers, TAG_W bits, wrap modulo DEPTH.
  - count, TAG_W+1 bits.
  - Per entry: done, wen, dest, data.
- Reset, while rst=1 and asynchronously on assertion:
  - head=tail=count=0, all done=0.
  - Outputs: disp_ready=1, disp_tag=0, empty=1, wen0=wen1=0, retire_cnt=0, waddr/wdata=0.
- Dispatch:
  - disp_ready = (count != DEPTH), computed from registered count only.
  - Accepted when disp_valid && disp_ready: entry[tail] gets done=0, wen, dest; tail increments.
  - disp_tag is valid in the same cycle as the accept.
- Completion:
  - cmpX_valid sets entry[tag].done=1 and writes entry[tag].data at the clock edge.
  - Both ports may complete different tags in the same cycle.
  - Same tag on both ports, or a tag outside head..tail-1, is illegal. Behaviour is undefined; the bench flags it with an assertion.
- Retire, combinational from registered state:
  - slot0 retires if count>=1 and entry[head].done.
  - slot1 retires if slot0 retires, count>=2, and entry[head+1].done.
  - A slot's wen equals the entry's wen bit AND its retire condition. Entries without a destination retire with wen=0 but still count in retire_cnt.
  - When both slots write the same dest, the register file applies wen1 last, so the younger value wins. No local merge is done.
  - Latency: a completion at edge N makes wen visible in cycle N+1, and the register file is updated at edge N+1, provided the entry is at the head.
  - Outputs are zero whenever a slot does not retire, including waddr and wdata.
- Pointer and count update per cycle:
  - head += retire_cnt.
  - count += accepted_dispatch - retire_cnt.
  - Dispatch, completion and retire may all occur in the same cycle.
  - A full buffer that retires in a cycle still reports disp_ready=0 for that cycle (no bypass).
- Wrap: head+1 indexes modulo DEPTH. Slot1 reads entry 0 when head=DEPTH-1.
- Flush:
  - Synchronous. wen0, wen1 and retire_cnt are forced to 0 in the flush cycle.
  - Dispatch and completion are ignored in the flush cycle.
  - At the next edge: head=tail=count=0, all done=0.
- Reset mid-operation: all in-flight entries are discarded; no write port asserts until new entries complete.

Decomposition:
- Shared package holds:
  - REG_W=16 and REG_ADDR_W=3, matching the register file.
  - The default DEPTH.
  - A rob_entry_t struct {done, wen, dest, data}.
- One sub-module is natural: rob_entry_array. It holds the DEPTH x entry storage with one allocate port, two completion write ports and two combinational read ports at head and head+1.
- Pointer, count and retire logic stay in rob_commit.

Test Plan:
- Reset then idle -> empty=1, disp_ready=1, wen0=wen1=0, retire_cnt=0 for 10 cycles.
- Dispatch tags 0,1 (dest 3, dest 5, both wen), then complete tag1=0x00AA before tag0=0x0055 -> nothing retires until tag0 is done. Next cycle: wen0=1 waddr0=3 wdata0=0x0055, wen1=1 waddr1=5 wdata1=0x00AA, retire_cnt=2.
- Dispatch two entries both with dest 2; complete both in one cycle with 0x1111 (older) and 0x2222 -> slot0 and slot1 both address 2; the register file holds 0x2222 afterwards.
- Dispatch 16 entries -> disp_ready=0 on the 17th request and that request is not accepted. Complete tag 0 -> one retire; the following cycle disp_ready=1 and disp_tag=0 (wrap).
- Entry with disp_wen=0 at head completes -> retire_cnt=1, wen0=0, head advances.
- Flush with 5 entries pending, some done -> no wen in the flush cycle. Next cycle empty=1 and disp_tag=0. Assert rst mid-stream -> outputs go to reset values immediately, without waiting for a clock edge.
